// File: rtl/tick_period_meter_pkg.sv
// Shared codes, state encoding and default constants for the tick period meter.
// Default thresholds sit midway between the periods of adjacent divider settings.
package tick_meter_pkg;

   typedef enum logic [1:0] {
      SPEED_SLOWER  = 2'd0,
      SPEED_NORMAL  = 2'd1,
      SPEED_FASTER  = 2'd2,
      SPEED_EXTREME = 2'd3
   } speed_t;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_MEASURE  = 2'd1,
      ST_STALLED  = 2'd2
   } state_t;

   localparam int unsigned CMP_EXTREME = 555555;
   localparam int unsigned CMP_FASTER  = 888888;
   localparam int unsigned CMP_NORMAL  = 1777777;
   localparam int unsigned CMP_SLOWER  = 3555555;

   // A divider with compare value N produces a tick every N+1 cycles.
   function automatic int unsigned period_of(input int unsigned cmp);
      return cmp + 1;
   endfunction

   localparam int unsigned DEF_THR_EXTREME = (period_of(CMP_EXTREME) + period_of(CMP_FASTER)) / 2;
   localparam int unsigned DEF_THR_FASTER  = (period_of(CMP_FASTER)  + period_of(CMP_NORMAL)) / 2;
   localparam int unsigned DEF_THR_NORMAL  = (period_of(CMP_NORMAL)  + period_of(CMP_SLOWER)) / 2;
   localparam int unsigned DEF_TIMEOUT     = 4000000;
   localparam int unsigned DEF_CNT_W       = 24;

endpackage

// File: rtl/tick_period_meter_if.sv
// Result channel of the tick period meter: measured data, valid/ready and status flags.
interface tick_period_meter_if #(
   parameter int unsigned CNT_W = 24
) ();
   logic [CNT_W-1:0] period_out;
   logic [1:0]       speed_level;
   logic             out_valid;
   logic             out_ready;
   logic             stalled;
   logic             overrun;

   modport master (
      output period_out, speed_level, out_valid, stalled, overrun,
      input  out_ready
   );

   modport slave (
      input  period_out, speed_level, out_valid, stalled, overrun,
      output out_ready
   );
endinterface

// File: rtl/tick_period_meter_speed_classifier.sv
// Combinational mapping of an interval length to one of the four speed levels.
module speed_classifier
   import tick_meter_pkg::*;
#(
   parameter int unsigned W           = DEF_CNT_W,
   parameter int unsigned THR_EXTREME = DEF_THR_EXTREME,
   parameter int unsigned THR_FASTER  = DEF_THR_FASTER,
   parameter int unsigned THR_NORMAL  = DEF_THR_NORMAL
) (
   input  logic [W-1:0] period,
   output speed_t       level
);
   localparam logic [W-1:0] T_EXTREME = W'(THR_EXTREME);
   localparam logic [W-1:0] T_FASTER  = W'(THR_FASTER);
   localparam logic [W-1:0] T_NORMAL  = W'(THR_NORMAL);

   always_comb begin
      if (period < T_EXTREME)
         level = SPEED_EXTREME;
      else if (period < T_FASTER)
         level = SPEED_FASTER;
      else if (period < T_NORMAL)
         level = SPEED_NORMAL;
      else
         level = SPEED_SLOWER;
   end
endmodule

// File: rtl/tick_period_meter.sv
// Measures cycles between successive ticks, classifies each interval and offers it
// on a valid/ready channel; a watchdog flags a tick source that has gone quiet.
module tick_period_meter
   import tick_meter_pkg::*;
#(
   parameter int unsigned CNT_W       = DEF_CNT_W,
   parameter int unsigned TIMEOUT     = DEF_TIMEOUT,
   parameter int unsigned THR_EXTREME = DEF_THR_EXTREME,
   parameter int unsigned THR_FASTER  = DEF_THR_FASTER,
   parameter int unsigned THR_NORMAL  = DEF_THR_NORMAL
) (
   input  logic              clkin,
   input  logic              resetn,
   input  logic              tick_in,
   tick_period_meter_if.master res
);
   localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

   state_t           state, state_d;
   logic [CNT_W-1:0] cnt, cnt_d;
   logic [CNT_W-1:0] period_q, period_d;
   logic [1:0]       level_q, level_d;
   logic             valid_q, valid_d;
   logic             stalled_q, stalled_d;
   logic             overrun_q, overrun_d;
   logic             at_timeout;
   logic             new_result;
   speed_t           cls_level;

   speed_classifier #(
      .W           (CNT_W),
      .THR_EXTREME (THR_EXTREME),
      .THR_FASTER  (THR_FASTER),
      .THR_NORMAL  (THR_NORMAL)
   ) u_classifier (
      .period (cnt),
      .level  (cls_level)
   );

   assign at_timeout = (cnt == TIMEOUT_C);
   assign new_result = (state == ST_MEASURE) && tick_in;

   always_ff @(posedge clkin) begin
      if (!resetn)
         state <= ST_IDLE;
      else
         state <= state_d;
   end

   // A tick on the timeout cycle still counts as a valid interval.
   always_comb begin
      state_d = state;
      case (state)
         ST_IDLE:    if (tick_in) state_d = ST_MEASURE;
         ST_MEASURE: if (!tick_in && at_timeout) state_d = ST_STALLED;
         ST_STALLED: if (tick_in) state_d = ST_MEASURE;
         default:    state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      cnt_d     = cnt;
      stalled_d = stalled_q;
      period_d  = period_q;
      level_d   = level_q;
      valid_d   = valid_q;
      overrun_d = overrun_q;

      case (state)
         ST_IDLE: begin
            if (tick_in) cnt_d = ONE;
         end
         ST_MEASURE: begin
            if (tick_in)
               cnt_d = ONE;
            else if (at_timeout)
               stalled_d = 1'b1;
            else
               cnt_d = cnt + ONE;
         end
         ST_STALLED: begin
            if (tick_in) begin
               cnt_d     = ONE;
               stalled_d = 1'b0;
            end
         end
         default: cnt_d = '0;
      endcase

      if (valid_q && res.out_ready)
         valid_d = 1'b0;
      if (new_result) begin
         period_d = cnt;
         level_d  = cls_level;
         valid_d  = 1'b1;
         if (valid_q && !res.out_ready)
            overrun_d = 1'b1;
      end
   end

   always_ff @(posedge clkin) begin
      if (!resetn) begin
         cnt       <= '0;
         period_q  <= '0;
         level_q   <= '0;
         valid_q   <= 1'b0;
         stalled_q <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         cnt       <= cnt_d;
         period_q  <= period_d;
         level_q   <= level_d;
         valid_q   <= valid_d;
         stalled_q <= stalled_d;
         overrun_q <= overrun_d;
      end
   end

   assign res.period_out  = period_q;
   assign res.speed_level = level_q;
   assign res.out_valid   = valid_q;
   assign res.stalled     = stalled_q;
   assign res.overrun     = overrun_q;
endmodule

// File: tb/tb_tick_period_meter.sv
// Bench for tick_period_meter: tick-history reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_tick_period_meter;
   localparam int unsigned W  = 8;
   localparam int unsigned TO = 20;
   localparam int unsigned TE = 4;
   localparam int unsigned TF = 8;
   localparam int unsigned TN = 12;

   logic clkin = 1'b0;
   logic resetn, tick_in, out_ready;
   int   checks = 0;
   int   errors = 0;
   bit   chk_en = 1'b0;

   tick_period_meter_if #(.CNT_W(W)) bus ();
   assign bus.out_ready = out_ready;

   tick_period_meter #(
      .CNT_W       (W),
      .TIMEOUT     (TO),
      .THR_EXTREME (TE),
      .THR_FASTER  (TF),
      .THR_NORMAL  (TN)
   ) dut (
      .clkin   (clkin),
      .resetn  (resetn),
      .tick_in (tick_in),
      .res     (bus)
   );

   always #5 clkin = ~clkin;

   // Reference model: expressed in terms of tick arrival times.
   int  mcyc = 0;
   int  last_tick = 0;
   bit  have_ref = 0;
   bit  m_stalled = 0, m_valid = 0, m_overrun = 0;
   int  m_period = 0, m_level = 0;

   function automatic int exp_level(input int p);
      if (p < TE) return 3;
      if (p < TF) return 2;
      if (p < TN) return 1;
      return 0;
   endfunction

   always @(posedge clkin) begin
      bit newres;
      int p;
      newres = 0;
      p = 0;
      if (!resetn) begin
         have_ref = 0; m_stalled = 0; m_valid = 0; m_overrun = 0;
         m_period = 0; m_level = 0;
      end else begin
         if (tick_in) begin
            if (have_ref && !m_stalled) begin
               newres = 1;
               p = mcyc - last_tick;
            end
            have_ref  = 1;
            last_tick = mcyc;
            m_stalled = 0;
         end else if (have_ref && !m_stalled && (mcyc - last_tick == TO)) begin
            m_stalled = 1;
         end
         if (newres) begin
            if (m_valid && !out_ready) m_overrun = 1;
            m_valid  = 1;
            m_period = p;
            m_level  = exp_level(p);
         end else if (m_valid && out_ready) begin
            m_valid = 0;
         end
      end
      mcyc++;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at t=%0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   always @(negedge clkin) begin
      if (chk_en) begin
         check("model.out_valid", 32'(bus.out_valid), 32'(m_valid));
         check("model.stalled",   32'(bus.stalled),   32'(m_stalled));
         check("model.overrun",   32'(bus.overrun),   32'(m_overrun));
         check("model.period",    32'(bus.period_out), 32'(m_period));
         check("model.level",     32'(bus.speed_level), 32'(m_level));
      end
   end

   task automatic drive(input logic t, input logic r, input logic rn = 1'b1);
      resetn = rn;
      tick_in = t;
      out_ready = r;
      @(posedge clkin);
      #1;
   endtask

   task automatic rst();
      drive(1'b0, 1'b1, 1'b0);
   endtask

   initial begin
      resetn = 1'b0; tick_in = 1'b0; out_ready = 1'b1;
      @(posedge clkin);
      #1;
      chk_en = 1'b1;
      check("reset.period",  32'(bus.period_out), 0);
      check("reset.level",   32'(bus.speed_level), 0);
      check("reset.valid",   32'(bus.out_valid), 0);
      check("reset.stalled", 32'(bus.stalled), 0);
      check("reset.overrun", 32'(bus.overrun), 0);

      // Ticks at 5 and 12
      for (int c = 0; c <= 13; c++) begin
         drive(c == 5 || c == 12, 1'b1);
         if (c == 11) check("t1.first_no_result", 32'(bus.out_valid), 0);
         if (c == 12) begin
            check("t1.period", 32'(bus.period_out), 7);
            check("t1.level",  32'(bus.speed_level), 2);
            check("t1.valid",  32'(bus.out_valid), 1);
         end
         if (c == 13) check("t1.valid_one_cycle", 32'(bus.out_valid), 0);
      end

      // Threshold boundaries: ticks at 3, 6, 16, 28
      rst();
      for (int c = 0; c <= 29; c++) begin
         drive(c == 3 || c == 6 || c == 16 || c == 28, 1'b1);
         if (c == 6)  begin check("t2.p3",  32'(bus.period_out), 3);  check("t2.l3", 32'(bus.speed_level), 3); end
         if (c == 16) begin check("t2.p10", 32'(bus.period_out), 10); check("t2.l1", 32'(bus.speed_level), 1); end
         if (c == 28) begin check("t2.p12", 32'(bus.period_out), 12); check("t2.l0", 32'(bus.speed_level), 0); end
      end

      // Stall: tick at 0, quiet until 30, then 35
      rst();
      for (int c = 0; c <= 36; c++) begin
         drive(c == 0 || c == 30 || c == 35, 1'b1);
         if (c == 19) check("t3.not_yet_stalled", 32'(bus.stalled), 0);
         if (c == 20) check("t3.stalled", 32'(bus.stalled), 1);
         if (c == 30) begin
            check("t3.unstalled", 32'(bus.stalled), 0);
            check("t3.no_result", 32'(bus.out_valid), 0);
         end
         if (c == 35) begin
            check("t3.period", 32'(bus.period_out), 5);
            check("t3.level",  32'(bus.speed_level), 2);
            check("t3.valid",  32'(bus.out_valid), 1);
         end
      end

      // Tick exactly at the timeout count
      rst();
      for (int c = 0; c <= 22; c++) begin
         drive(c == 0 || c == 20, 1'b1);
         if (c == 20) begin
            check("t4.period",  32'(bus.period_out), 20);
            check("t4.level",   32'(bus.speed_level), 0);
            check("t4.valid",   32'(bus.out_valid), 1);
         end
         if (c >= 19) check("t4.no_stall", 32'(bus.stalled), 0);
      end

      // Backpressure and overwrite
      rst();
      for (int c = 0; c <= 11; c++) begin
         drive(c == 0 || c == 5 || c == 9, c >= 10);
         if (c == 5) check("t5.no_overrun_yet", 32'(bus.overrun), 0);
         if (c == 9) begin
            check("t5.period",  32'(bus.period_out), 4);
            check("t5.valid",   32'(bus.out_valid), 1);
            check("t5.overrun", 32'(bus.overrun), 1);
         end
         if (c == 10) begin
            check("t5.accepted",      32'(bus.out_valid), 0);
            check("t5.overrun_stays", 32'(bus.overrun), 1);
         end
      end

      // Reset between ticks at 2 and 10
      rst();
      for (int c = 0; c <= 15; c++) begin
         drive(c == 2 || c == 10 || c == 14, 1'b1, c != 7);
         if (c == 7) begin
            check("t6.period",  32'(bus.period_out), 0);
            check("t6.valid",   32'(bus.out_valid), 0);
            check("t6.overrun", 32'(bus.overrun), 0);
         end
         if (c == 10) check("t6.first_tick", 32'(bus.out_valid), 0);
         if (c == 14) begin
            check("t6.period_after", 32'(bus.period_out), 4);
            check("t6.level_after",  32'(bus.speed_level), 2);
         end
      end

      // Randomized traffic with varying tick density
      rst();
      for (int blk = 0; blk < 30; blk++) begin
         int unsigned mode;
         mode = $urandom_range(0, 2);
         for (int c = 0; c < 100; c++) begin
            logic t;
            case (mode)
               0:       t = ($urandom_range(0, 1) == 0);
               1:       t = ($urandom_range(0, 7) == 0);
               default: t = ($urandom_range(0, 29) == 0);
            endcase
            drive(t, $urandom_range(0, 3) != 0, $urandom_range(0, 299) != 0);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
